ghash_ctrl: RTL and testbench

- GHASH sequencer for the AES-GCM core, acting as the initiator that drives the serial bit-per-cycle GF(2^128) multiplier.
- Accepts 128-bit blocks (AAD, ciphertext, length block) over a valid/ready stream.
- Forms Y = (Y ^ X) and hands each product to the multiplier together with hash key H.
- Captures the multiplier result and emits the final GHASH value as the tag pre-image.

---
 rtl/gcm_pkg.sv | 19 +
 rtl/ghash_mul.sv | 57 +++++
 rtl/ghash_ctrl.sv | 123 ++++++++++++
 tb/tb_ghash_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// Shared constants and types for the AES-GCM GHASH datapath.
package gcm_pkg;

  localparam int BLK_W = 128;

  // Reduction constant 1 + x + x^2 + x^7 in GCM bit order (bit 0 = x^0).
  localparam logic [0:BLK_W-1] GF_R = {8'he1, 120'b0};

  // Product strobe arrives on the 129th consecutive valid cycle.
  localparam int MUL_CYCLES = 129;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    MUL,
    DONE
  } ghash_state_t;

endpackage

// File: rtl/ghash_mul.sv
// Serial bit-per-cycle GF(2^128) multiplier. It steps one bit of A per cycle
// and strobes the product on the 129th cycle that both operand valids are high.
module ghash_mul
  import gcm_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [0:BLK_W-1] iA,
  input  logic             iA_valid,
  input  logic [0:BLK_W-1] iH,
  input  logic             iH_valid,
  output logic [0:BLK_W-1] oResult,
  output logic             oResult_valid
);

  localparam logic [7:0] CNT_LAST = 8'(MUL_CYCLES - 1);

  logic [7:0]       count_reg;
  logic [0:BLK_W-1] z_reg;
  logic [0:BLK_W-1] v_reg;
  logic [0:BLK_W-1] z_cur;
  logic [0:BLK_W-1] v_cur;
  logic [0:BLK_W-1] z_next;
  logic [0:BLK_W-1] v_next;
  logic             active;

  assign active = iA_valid & iH_valid;

  // Step 0 seeds the accumulator from the operands instead of the registers,
  // so no separate load cycle is needed.
  always_comb begin
    z_cur  = (count_reg == 8'd0) ? '0 : z_reg;
    v_cur  = (count_reg == 8'd0) ? iH : v_reg;
    z_next = iA[count_reg[6:0]] ? (z_cur ^ v_cur) : z_cur;
    v_next = v_cur[BLK_W-1] ? ((v_cur >> 1) ^ GF_R) : (v_cur >> 1);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      count_reg <= 8'd0;
      z_reg     <= '0;
      v_reg     <= '0;
    end else if (!active) begin
      count_reg <= 8'd0;
    end else if (count_reg == CNT_LAST) begin
      count_reg <= 8'd0;
    end else begin
      count_reg <= count_reg + 8'd1;
      z_reg     <= z_next;
      v_reg     <= v_next;
    end
  end

  assign oResult       = z_reg;
  assign oResult_valid = active && (count_reg == CNT_LAST);

endmodule

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: folds each accepted block into Y = (Y ^ X) * H using the
// external serial multiplier, and emits the final Y as the tag pre-image.
module ghash_ctrl
  import gcm_pkg::*;
#(
  parameter int MUL_TIMEOUT = 200
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [0:BLK_W-1] iH,
  input  logic             iH_load,
  input  logic             iInit,
  input  logic [0:BLK_W-1] iBlk,
  input  logic             iBlk_valid,
  input  logic             iBlk_last,
  output logic             oBlk_ready,
  output logic [0:BLK_W-1] oMulA,
  output logic             oMulA_valid,
  output logic [0:BLK_W-1] oMulH,
  output logic             oMulH_valid,
  input  logic [0:BLK_W-1] iMulResult,
  input  logic             iMulResult_valid,
  output logic [0:BLK_W-1] oTag,
  output logic             oTag_valid,
  output logic             oErr
);

  localparam int               TMO_W    = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MUL_TIMEOUT - 1);

  ghash_state_t     state_reg;
  logic [0:BLK_W-1] y_reg;
  logic [0:BLK_W-1] h_reg;
  logic             h_ok_reg;
  logic             last_reg;
  logic             mul_valid_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;

  assign oMulH       = h_reg;
  assign oMulA_valid = mul_valid_reg;
  assign oMulH_valid = mul_valid_reg;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_reg     <= IDLE;
      y_reg         <= '0;
      h_reg         <= '0;
      h_ok_reg      <= 1'b0;
      last_reg      <= 1'b0;
      mul_valid_reg <= 1'b0;
      tmo_cnt_reg   <= '0;
      oBlk_ready    <= 1'b0;
      oMulA         <= '0;
      oTag          <= '0;
      oTag_valid    <= 1'b0;
      oErr          <= 1'b0;
    end else begin
      oTag_valid <= 1'b0;

      // H must not move under the multiplier while it is indexing it.
      if (iH_load && (state_reg != MUL)) begin
        h_reg    <= iH;
        h_ok_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (iInit && h_ok_reg) begin
            y_reg      <= '0;
            oBlk_ready <= 1'b1;
            state_reg  <= ACCEPT;
          end
        end

        ACCEPT: begin
          if (iBlk_valid) begin
            // A same-cycle iInit restarts the message with this block as its first.
            oMulA         <= (iInit ? '0 : y_reg) ^ iBlk;
            last_reg      <= iBlk_last;
            oBlk_ready    <= 1'b0;
            mul_valid_reg <= 1'b1;
            tmo_cnt_reg   <= '0;
            state_reg     <= MUL;
          end
          if (iInit) begin
            y_reg <= '0;
          end
        end

        MUL: begin
          if (iMulResult_valid) begin
            // Dropping valids on the strobe edge leaves the multiplier idle at count 0.
            y_reg         <= iMulResult;
            mul_valid_reg <= 1'b0;
            if (last_reg) begin
              oTag       <= iMulResult;
              oTag_valid <= 1'b1;
              state_reg  <= DONE;
            end else begin
              oBlk_ready <= 1'b1;
              state_reg  <= ACCEPT;
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            oErr          <= 1'b1;
            mul_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Bench for ghash_ctrl paired with ghash_mul; expected tags come from a
// polynomial-arithmetic GHASH model and known GCM answers.
module tb_ghash_ctrl;
  import gcm_pkg::*;

  localparam logic [0:127] KAT_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] KAT_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [0:127] KAT_L   = 128'h00000000000000000000000000000080;
  localparam logic [0:127] KAT_TAG = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  logic         iClk = 1'b0;
  logic         iRst = 1'b1;
  logic [0:127] iH = '0;
  logic         iH_load = 1'b0;
  logic         iInit = 1'b0;
  logic [0:127] iBlk = '0;
  logic         iBlk_valid = 1'b0;
  logic         iBlk_last = 1'b0;
  logic         oBlk_ready;
  logic [0:127] oMulA;
  logic         oMulA_valid;
  logic [0:127] oMulH;
  logic         oMulH_valid;
  logic [0:127] iMulResult;
  logic         iMulResult_valid;
  logic [0:127] oTag;
  logic         oTag_valid;
  logic         oErr;

  logic [0:127] mul_res;
  logic         mul_res_valid;
  logic         suppress = 1'b0;
  logic         fake_strobe = 1'b0;
  logic [0:127] fake_data = '0;

  int checks = 0;
  int failures = 0;

  logic [0:127] msg_q[$];
  logic [0:127] h_model;

  always #5 iClk = ~iClk;

  // Strobe path: the real multiplier, gated for the timeout case, plus an
  // injected stray strobe that the controller must ignore outside MUL.
  assign iMulResult_valid = fake_strobe | (mul_res_valid & ~suppress);
  assign iMulResult       = fake_strobe ? fake_data : mul_res;

  ghash_ctrl #(.MUL_TIMEOUT(200)) dut (
    .iClk            (iClk),
    .iRst            (iRst),
    .iH              (iH),
    .iH_load         (iH_load),
    .iInit           (iInit),
    .iBlk            (iBlk),
    .iBlk_valid      (iBlk_valid),
    .iBlk_last       (iBlk_last),
    .oBlk_ready      (oBlk_ready),
    .oMulA           (oMulA),
    .oMulA_valid     (oMulA_valid),
    .oMulH           (oMulH),
    .oMulH_valid     (oMulH_valid),
    .iMulResult      (iMulResult),
    .iMulResult_valid(iMulResult_valid),
    .oTag            (oTag),
    .oTag_valid      (oTag_valid),
    .oErr            (oErr)
  );

  ghash_mul u_mul (
    .iClk         (iClk),
    .iRst_n       (~iRst),
    .iA           (oMulA),
    .iA_valid     (oMulA_valid),
    .iH           (oMulH),
    .iH_valid     (oMulH_valid),
    .oResult      (mul_res),
    .oResult_valid(mul_res_valid)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Field product as polynomials: bit k of a GCM block is the x^k coefficient.
  // Carry-less multiply, then reduce modulo x^128 + x^7 + x^2 + x + 1.
  function automatic logic [0:127] gf_mul(input logic [0:127] a, input logic [0:127] b);
    logic [254:0] p;
    logic [254:0] bpoly;
    logic [0:127] r;
    p     = '0;
    bpoly = '0;
    for (int k = 0; k < 128; k++) bpoly[k] = b[k];
    for (int i = 0; i < 128; i++) if (a[i]) p = p ^ (bpoly << i);
    for (int d = 254; d >= 128; d--) begin
      if (p[d]) begin
        p[d]       = 1'b0;
        p[d - 121] = ~p[d - 121];
        p[d - 126] = ~p[d - 126];
        p[d - 127] = ~p[d - 127];
        p[d - 128] = ~p[d - 128];
      end
    end
    for (int k = 0; k < 128; k++) r[k] = p[k];
    return r;
  endfunction

  task automatic load_h(input logic [0:127] h);
    iH = h;
    iH_load = 1'b1;
    tick();
    iH_load = 1'b0;
    h_model = h;
  endtask

  // Runs msg_q as one message; inject adds a stray strobe in ACCEPT and an
  // iH_load during each MUL, neither of which may affect the result.
  task automatic run_msg(input string tag, input bit inject);
    logic [0:127] y;
    int n;
    int w;
    bit last;
    y = '0;
    iInit = 1'b1;
    tick();
    iInit = 1'b0;
    if (inject) begin
      fake_data = rand128();
      fake_strobe = 1'b1;
      tick();
      fake_strobe = 1'b0;
    end
    for (int i = 0; i < msg_q.size(); i++) begin
      last = (i == msg_q.size() - 1);
      w = 0;
      while (!oBlk_ready && w < 400) begin
        tick();
        w++;
      end
      check({tag, "_ready"}, oBlk_ready, 1);
      iBlk = msg_q[i];
      iBlk_last = last;
      iBlk_valid = 1'b1;
      tick();
      iBlk_valid = 1'b0;
      iBlk_last = 1'b0;
      check({tag, "_mula"}, oMulA, y ^ msg_q[i]);
      y = gf_mul(y ^ msg_q[i], h_model);
      n = 1;
      while (!(oTag_valid || oBlk_ready) && n < 400) begin
        if (inject) begin
          iH_load = (n == 5);
          iH = rand128();
        end
        tick();
        n++;
      end
      iH_load = 1'b0;
      check({tag, "_latency"}, n, 130);
      if (last) begin
        check({tag, "_tag_valid"}, oTag_valid, 1);
        check({tag, "_tag"}, oTag, y);
        $display("msg %s blocks=%0d tag=%h", tag, msg_q.size(), oTag);
        tick();
        check({tag, "_tag_pulse"}, oTag_valid, 0);
        check({tag, "_mulh"}, oMulH, h_model);
      end else begin
        check({tag, "_no_tag"}, oTag_valid, 0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, oBlk_ready, 0);
    check({tag, "_mula_valid"}, oMulA_valid, 0);
    check({tag, "_mulh_valid"}, oMulH_valid, 0);
    check({tag, "_mula"}, oMulA, 0);
    check({tag, "_mulh"}, oMulH, 0);
    check({tag, "_tag"}, oTag, 0);
    check({tag, "_tag_valid"}, oTag_valid, 0);
    check({tag, "_err"}, oErr, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:127] a0;
    logic [0:127] blk;
    int bad;
    int n;

    repeat (3) tick();
    iRst = 1'b0;
    tick();
    check_reset_outputs("reset");

    // iInit without a loaded key must not open the block port.
    iInit = 1'b1;
    tick();
    iInit = 1'b0;
    repeat (3) tick();
    check("init_no_h", oBlk_ready, 0);

    load_h(KAT_H);
    msg_q = '{128'h0};
    run_msg("zero_blk", 1'b0);
    check("zero_blk_kat", oTag, 0);

    msg_q = '{KAT_C, KAT_L};
    run_msg("kat", 1'b0);
    check("kat_tag", oTag, KAT_TAG);

    run_msg("kat_reuse", 1'b1);
    check("kat_reuse_tag", oTag, KAT_TAG);

    // Backpressure: the next block is held valid (and marked last) during MUL.
    iInit = 1'b1;
    tick();
    iInit = 1'b0;
    iBlk = KAT_C;
    iBlk_last = 1'b0;
    iBlk_valid = 1'b1;
    tick();
    iBlk = KAT_L;
    iBlk_last = 1'b1;
    a0 = oMulA;
    bad = 0;
    for (int c = 1; c <= 129; c++) begin
      if (oBlk_ready || !oMulA_valid || !oMulH_valid || (oMulA !== a0)) bad++;
      tick();
    end
    check("bp_hold_cycles_bad", bad, 0);
    check("bp_mula_first", a0, KAT_C);
    check("bp_ready_c130", oBlk_ready, 1);
    check("bp_no_early_tag", oTag_valid, 0);
    tick();
    iBlk_valid = 1'b0;
    iBlk_last = 1'b0;
    check("bp_mula_second", oMulA, gf_mul(KAT_C, KAT_H) ^ KAT_L);
    n = 1;
    while (!oTag_valid && n < 400) begin
      tick();
      n++;
    end
    check("bp_latency", n, 130);
    check("bp_tag", oTag, KAT_TAG);
    $display("msg backpressure blocks=2 tag=%h", oTag);
    tick();

    for (int m = 0; m < 6; m++) begin
      load_h(rand128());
      msg_q.delete();
      for (int b = 0; b < $urandom_range(1, 4); b++) msg_q.push_back(rand128());
      run_msg($sformatf("rnd%0d", m), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a product.
    load_h(KAT_H);
    iInit = 1'b1;
    tick();
    iInit = 1'b0;
    iBlk = KAT_C;
    iBlk_valid = 1'b1;
    tick();
    iBlk_valid = 1'b0;
    repeat (59) tick();
    check("mid_reset_in_mul", oMulA_valid, 1);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check_reset_outputs("mid_reset");
    load_h(KAT_H);
    msg_q = '{KAT_C, KAT_L};
    run_msg("post_reset", 1'b0);
    check("post_reset_kat", oTag, KAT_TAG);

    // Multiplier strobe suppressed: timeout after 200 MUL cycles.
    suppress = 1'b1;
    blk = rand128();
    iInit = 1'b1;
    tick();
    iInit = 1'b0;
    iBlk = blk;
    iBlk_last = 1'b1;
    iBlk_valid = 1'b1;
    tick();
    iBlk_valid = 1'b0;
    iBlk_last = 1'b0;
    repeat (199) tick();
    check("tmo_err_c200", oErr, 0);
    check("tmo_valid_c200", oMulA_valid, 1);
    tick();
    check("tmo_err_c201", oErr, 1);
    check("tmo_mula_valid", oMulA_valid, 0);
    check("tmo_mulh_valid", oMulH_valid, 0);
    check("tmo_ready", oBlk_ready, 0);
    check("tmo_no_tag", oTag_valid, 0);
    suppress = 1'b0;
    repeat (5) tick();
    check("tmo_err_sticky", oErr, 1);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check("tmo_err_cleared", oErr, 0);
    iInit = 1'b1;
    tick();
    iInit = 1'b0;
    repeat (3) tick();
    check("init_no_h_again", oBlk_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
